// File: rtl/riscv_run_ctrl.sv
// Run/reset controller for the single-cycle RISC-V core: stretches reset into core_rst
// and gates execution through core_ce (free-run, single-step, breakpoint and cycle-limit halt).
module riscv_run_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_BP     = 2,
    parameter int unsigned BP_IDX_W   = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter bit          AUTO_RUN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     soft_rst,
    input  logic                     run_req,
    input  logic                     step_req,
    input  logic                     halt_req,
    input  logic [XLEN-1:0]          pc,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*XLEN-1:0]   bp_addr,
    input  logic [CNT_W-1:0]         max_cycles,
    output logic                     core_rst,
    output logic                     core_ce,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [BP_IDX_W-1:0]      bp_idx,
    output logic [CNT_W-1:0]         cycle_count
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_EXT   = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_RESUME   = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_nxt;
    logic [1:0]            r_halt_cause;
    logic [1:0]            w_cause_nxt;
    logic [BP_IDX_W-1:0]   r_bp_idx;
    logic [CNT_W-1:0]      r_cycle_count;
    logic                  w_bp_hit;
    logic [BP_IDX_W-1:0]   w_bp_first;
    logic                  w_bp_latch;
    logic                  w_limit_hit;

    // Lowest-index enabled comparator that matches the current PC
    always_comb begin
        w_bp_hit   = 1'b0;
        w_bp_first = '0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (!w_bp_hit && bp_en[i] && (pc == bp_addr[i*XLEN +: XLEN])) begin
                w_bp_hit   = 1'b1;
                w_bp_first = BP_IDX_W'(i);
            end
        end
    end

    assign w_limit_hit = (max_cycles != '0) && (r_cycle_count == max_cycles);

    // Next state and the combinational core controls
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_cause_nxt = r_halt_cause;
        w_bp_latch  = 1'b0;
        core_rst    = 1'b0;
        core_ce     = 1'b0;
        halted      = 1'b0;

        case (r_state)
            ST_RST_HOLD: begin
                core_rst = 1'b1;
                if (r_hold_cnt == '0) begin
                    w_state_nxt = AUTO_RUN ? ST_RUN : ST_HALTED;
                end else begin
                    w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // Halting suppresses core_ce in the same cycle, so the breakpoint PC is not executed
                if (w_bp_hit) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_BP;
                    w_bp_latch  = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_EXT;
                end else if (w_limit_hit) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_LIMIT;
                end else begin
                    core_ce = 1'b1;
                end
            end
            ST_STEP: begin
                core_ce     = 1'b1;
                w_state_nxt = ST_HALTED;
            end
            ST_RESUME: begin
                core_ce     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (run_req) begin
                    w_state_nxt = ST_RESUME;
                end else if (step_req) begin
                    w_state_nxt = ST_STEP;
                end
            end
            default: begin
                w_state_nxt = ST_RST_HOLD;
                w_hold_nxt  = HOLD_INIT;
            end
        endcase
    end

    // State, hold counter, halt bookkeeping and executed-cycle counter
    always_ff @(posedge clk) begin
        if (reset || soft_rst) begin
            r_state       <= ST_RST_HOLD;
            r_hold_cnt    <= HOLD_INIT;
            r_halt_cause  <= CAUSE_NONE;
            r_bp_idx      <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_halt_cause <= w_cause_nxt;
            if (w_bp_latch) begin
                r_bp_idx <= w_bp_first;
            end
            if (core_ce) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign halt_cause  = r_halt_cause;
    assign bp_idx      = r_bp_idx;
    assign cycle_count = r_cycle_count;

endmodule
